debounce_multi: RTL and testbench



---
 rtl/debounce_multi.sv | 109 ++++++++++
 tb/tb_debounce_multi.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchronised input debouncer with press/release pulses
// and optional hold-to-repeat pulses, all channels independent in one clock domain.
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int CNT_WIDTH     = 19,
    parameter int INVERT        = 0,
    parameter int REPEAT_EN     = 1,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] Input,
    output logic [CHANNELS-1:0] State,
    output logic [CHANNELS-1:0] Press,
    output logic [CHANNELS-1:0] Release,
    output logic [CHANNELS-1:0] Repeat,
    output logic                AnyPress
);
    localparam logic [CHANNELS-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;
    localparam int HOLD_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HOLD_MAX);

    logic [CHANNELS-1:0] sync0, sync1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= Input ^ INV_MASK;
            sync1 <= sync0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic st, pr, rl, rp, flip;
        // the level flips only after a full window of uninterrupted mismatches
        assign flip = (sync1[g] != st) && (&cnt);
        always_ff @(posedge Clk) begin
            if (Reset) begin
                cnt <= '0;
                st  <= 1'b0;
                pr  <= 1'b0;
                rl  <= 1'b0;
            end else begin
                cnt <= (sync1[g] == st || (&cnt)) ? '0 : cnt + 1'b1;
                st  <= st ^ flip;
                pr  <= flip & ~st;
                rl  <= flip & st;
            end
        end
        if (REPEAT_EN != 0) begin : g_hold
            typedef enum logic [1:0] {IDLE, WAIT, REPEATING} hold_t;
            hold_t hs, hs_n;
            logic [HW-1:0] hc, hc_n;
            logic rp_n, rise, fall;
            assign rise = flip & ~st;
            assign fall = flip & st;
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    hs <= IDLE;
                    hc <= '0;
                    rp <= 1'b0;
                end else begin
                    hs <= hs_n;
                    hc <= hc_n;
                    rp <= rp_n;
                end
            end
            always_comb begin
                hs_n = hs;
                hc_n = hc + 1'b1;
                rp_n = 1'b0;
                case (hs)
                    IDLE: begin
                        hc_n = '0;
                        hs_n = rise ? WAIT : IDLE;
                    end
                    WAIT: if (hc == HW'(HOLD_DELAY - 1)) begin
                        rp_n = 1'b1;
                        hs_n = REPEATING;
                        hc_n = '0;
                    end
                    REPEATING: if (hc == HW'(REPEAT_PERIOD - 1)) begin
                        rp_n = 1'b1;
                        hc_n = '0;
                    end
                    default: hs_n = IDLE;
                endcase
                // a release on the same edge cancels any repeat due then
                if (fall) begin
                    hs_n = IDLE;
                    hc_n = '0;
                    rp_n = 1'b0;
                end
            end
        end else begin : g_norep
            assign rp = 1'b0;
        end
        assign State[g]   = st;
        assign Press[g]   = pr;
        assign Release[g] = rl;
        assign Repeat[g]  = rp;
    end

    assign AnyPress = |Press;
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed table and hand sequences for debounce_multi, with an
// active-high and an active-low instance sharing clock and reset.
module tb_debounce_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in0 = 4'hF;
    logic [3:0] in1 = 4'hF;
    logic [3:0] st0, pr0, rl0, rp0, st1, pr1, rl1, rp1;
    logic any0, any1;
    logic [16:0] act0, act1;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .CNT_WIDTH(3), .INVERT(0), .REPEAT_EN(1),
                     .HOLD_DELAY(20), .REPEAT_PERIOD(5)) d0 (
        .Clk(clk), .Reset(rst), .Input(in0), .State(st0), .Press(pr0),
        .Release(rl0), .Repeat(rp0), .AnyPress(any0));

    debounce_multi #(.CHANNELS(4), .CNT_WIDTH(3), .INVERT(1), .REPEAT_EN(1),
                     .HOLD_DELAY(20), .REPEAT_PERIOD(5)) d1 (
        .Clk(clk), .Reset(rst), .Input(in1), .State(st1), .Press(pr1),
        .Release(rl1), .Repeat(rp1), .AnyPress(any1));

    assign act0 = {st0, pr0, rl0, rp0, any0};
    assign act1 = {st1, pr1, rl1, rp1, any1};

    typedef struct {
        logic        rst;
        logic [3:0]  in;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [16:0] o(input logic [3:0] st, input logic [3:0] pr,
                                      input logic [3:0] rl, input logic [3:0] rp);
        return {st, pr, rl, rp, |pr};
    endfunction

    task automatic add(input logic r, input logic [3:0] i, input logic [16:0] e, input int n);
        vec_t v;
        v.rst = r;
        v.in  = i;
        v.exp = e;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st/pr/rl/rp/any=%h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // reset with inputs high, full window, then release of all channels
        add(1, 4'hF, o(0, 0, 0, 0), 2);
        add(0, 4'hF, o(0, 0, 0, 0), 9);
        add(0, 4'hF, o(4'hF, 4'hF, 0, 0), 1);
        add(0, 4'hF, o(4'hF, 0, 0, 0), 1);
        add(0, 4'h0, o(4'hF, 0, 0, 0), 9);
        add(0, 4'h0, o(0, 0, 4'hF, 0), 1);
        add(0, 4'h0, o(0, 0, 0, 0), 1);
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            in0 = tbl[i].in;
            tick();
            chk($sformatf("table%0d", i), act0, tbl[i].exp);
        end
        rst = 1'b0;
        in0 = 4'h0;

        // clean press and release on channel 0
        in0 = 4'h1;
        for (int t = 0; t <= 10; t++) begin
            tick();
            chk($sformatf("ch0_press_t%0d", t), act0,
                t == 9 ? o(1, 1, 0, 0) : t == 10 ? o(1, 0, 0, 0) : o(0, 0, 0, 0));
        end
        in0 = 4'h0;
        for (int t = 0; t <= 10; t++) begin
            tick();
            chk($sformatf("ch0_release_t%0d", t), act0,
                t == 9 ? o(0, 0, 1, 0) : t == 10 ? o(0, 0, 0, 0) : o(1, 0, 0, 0));
        end

        // bounce on channel 1: toggling every 4 cycles never reaches the window
        for (int t = 0; t <= 50; t++) begin
            in0[1] = (t < 40) ? ((t / 4) % 2 == 0) : 1'b1;
            tick();
            chk($sformatf("ch1_bounce_t%0d", t), act0,
                t == 49 ? o(2, 2, 0, 0) : t == 50 ? o(2, 0, 0, 0) : o(0, 0, 0, 0));
        end
        in0 = 4'h0;
        for (int t = 0; t <= 10; t++) begin
            tick();
            chk($sformatf("ch1_release_t%0d", t), act0,
                t == 9 ? o(0, 0, 2, 0) : t == 10 ? o(0, 0, 0, 0) : o(2, 0, 0, 0));
        end

        // auto-repeat on channel 2; release lands on the cycle a repeat was due
        for (int t = 0; t <= 60; t++) begin
            in0[2] = (t < 45);
            tick();
            chk($sformatf("ch2_repeat_t%0d", t), act0,
                o((t >= 9 && t < 54) ? 4'h4 : 4'h0,
                  (t == 9) ? 4'h4 : 4'h0,
                  (t == 54) ? 4'h4 : 4'h0,
                  (t >= 29 && t <= 49 && (t - 29) % 5 == 0) ? 4'h4 : 4'h0));
        end
        in0 = 4'h0;

        // reset with ch2 repeating and ch3 mid-window, then a full window again
        for (int t = 0; t <= 43; t++) begin
            rst = (t == 32);
            in0 = {(t >= 25), 1'b1, 2'b00};
            tick();
            if (t < 32)
                chk($sformatf("rst_pre_t%0d", t), act0,
                    o((t >= 9) ? 4'h4 : 4'h0, (t == 9) ? 4'h4 : 4'h0, 0,
                      (t == 29) ? 4'h4 : 4'h0));
            else
                chk($sformatf("rst_post_t%0d", t), act0,
                    t == 42 ? o(4'hC, 4'hC, 0, 0) : t == 43 ? o(4'hC, 0, 0, 0) : o(0, 0, 0, 0));
        end
        rst = 1'b1;
        in0 = 4'h0;
        tick();
        chk("rst_clear", act0, o(0, 0, 0, 0));
        rst = 1'b0;

        // active-low instance: idle-high inputs read as 0, pulling ch0 low presses it
        for (int t = 0; t < 10; t++) begin
            tick();
            chk($sformatf("inv_idle_t%0d", t), act1, o(0, 0, 0, 0));
        end
        in1 = 4'hE;
        for (int t = 0; t <= 10; t++) begin
            tick();
            chk($sformatf("inv_press_t%0d", t), act1,
                t == 9 ? o(1, 1, 0, 0) : t == 10 ? o(1, 0, 0, 0) : o(0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
